// File: rtl/pc_exc_pkg.sv
// rtl/pc_exc_pkg.sv - shared defaults and next-PC select encoding for the PC/exception unit
package pc_exc_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam int          N_EXC_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] VEC_PC_DEF   = 32'h0000_0080;

  typedef enum logic [2:0] {
    SEL_LOAD,
    SEL_HOLD,
    SEL_EXC,
    SEL_ERET,
    SEL_JUMP,
    SEL_BR,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/pc_exc_unit_if.sv
// rtl/pc_exc_unit_if.sv - control inputs and PC/exception state outputs of pc_exc_unit
interface pc_exc_unit_if #(
  parameter int PC_W  = 32,
  parameter int N_EXC = 4
) ();
  localparam int CAUSE_W = $clog2(N_EXC);

  logic               stall;
  logic               load;
  logic [PC_W-1:0]    load_val;
  logic               branch_taken;
  logic [15:0]        branch_off;
  logic               jump;
  logic [25:0]        jump_idx;
  logic [N_EXC-1:0]   exc_req;
  logic               eret;
  logic               mask_we;
  logic [N_EXC-1:0]   mask_wdata;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    epc;
  logic [CAUSE_W-1:0] cause;
  logic               exl;
  logic               exc_taken;
  logic [N_EXC-1:0]   mask;

  modport master (
    output stall, load, load_val, branch_taken, branch_off, jump, jump_idx,
           exc_req, eret, mask_we, mask_wdata,
    input  pc, pc_plus4, epc, cause, exl, exc_taken, mask
  );

  modport slave (
    input  stall, load, load_val, branch_taken, branch_off, jump, jump_idx,
           exc_req, eret, mask_we, mask_wdata,
    output pc, pc_plus4, epc, cause, exl, exc_taken, mask
  );
endinterface

// File: rtl/pc_exc_unit_prio_enc.sv
// rtl/pc_exc_unit_prio_enc.sv - lowest-set-bit priority encoder (bit 0 wins)
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);
  // Scan high to low so the last hit, the lowest index, is kept.
  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end
endmodule

// File: rtl/pc_exc_unit.sv
// rtl/pc_exc_unit.sv - program counter with branch/jump/load and single-level exception entry/return
module pc_exc_unit
  import pc_exc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              N_EXC    = N_EXC_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter logic [PC_W-1:0] VEC_PC   = PC_W'(VEC_PC_DEF)
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  pc_exc_unit_if.slave bus
);
  localparam int CAUSE_W = $clog2(N_EXC);

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_exl;
  logic               r_exc_taken;
  logic [N_EXC-1:0]   r_mask;

  logic [PC_W-1:0]    w_pc_plus4;
  logic [PC_W-1:0]    w_br_off;
  logic [PC_W-1:0]    w_jump_pc;
  logic [PC_W-1:0]    w_next_pc;
  logic [N_EXC-1:0]   w_masked;
  logic [CAUSE_W-1:0] w_idx;
  logic               w_any;
  logic               w_accept;
  next_sel_e          w_sel;

  assign w_pc_plus4 = r_pc + PC_W'(4);
  assign w_br_off   = {{(PC_W-18){bus.branch_off[15]}}, bus.branch_off, 2'b00};
  // Jump keeps the 256 MB region of the sequential successor; written as a mask so PC_W = 28 works.
  assign w_jump_pc  = (w_pc_plus4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({bus.jump_idx, 2'b00});
  assign w_masked   = bus.exc_req & r_mask;

  prio_enc #(.N(N_EXC), .W(CAUSE_W)) u_prio (
    .i_req   (w_masked),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_accept = !bus.load && !bus.stall && !r_exl && w_any;

  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.load)               w_sel = SEL_LOAD;
    else if (bus.stall)         w_sel = SEL_HOLD;
    else if (w_accept)          w_sel = SEL_EXC;
    else if (bus.eret && r_exl) w_sel = SEL_ERET;
    else if (bus.jump)          w_sel = SEL_JUMP;
    else if (bus.branch_taken)  w_sel = SEL_BR;
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      SEL_LOAD: w_next_pc = {bus.load_val[PC_W-1:2], 2'b00};
      SEL_HOLD: w_next_pc = r_pc;
      SEL_EXC:  w_next_pc = VEC_PC;
      SEL_ERET: w_next_pc = r_epc;
      SEL_JUMP: w_next_pc = w_jump_pc;
      SEL_BR:   w_next_pc = w_pc_plus4 + w_br_off;
      default:  w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_pc        <= RESET_PC;
      r_epc       <= '0;
      r_cause     <= '0;
      r_exl       <= 1'b0;
      r_exc_taken <= 1'b0;
      r_mask      <= '1;
    end else begin
      r_pc        <= w_next_pc;
      r_exc_taken <= (w_sel == SEL_EXC);
      if (w_sel == SEL_EXC) begin
        r_epc   <= r_pc;
        r_cause <= w_idx;
        r_exl   <= 1'b1;
      end else if (w_sel == SEL_ERET) begin
        r_exl <= 1'b0;
      end
      // The acceptance above already saw the pre-write mask.
      if (bus.mask_we) r_mask <= bus.mask_wdata;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.epc       = r_epc;
  assign bus.cause     = r_cause;
  assign bus.exl       = r_exl;
  assign bus.exc_taken = r_exc_taken;
  assign bus.mask      = r_mask;
endmodule

// File: tb/tb_pc_exc_unit.sv
// tb/tb_pc_exc_unit.sv - directed and random checks of pc_exc_unit against a behavioural model
module tb_pc_exc_unit;
  logic SYS_clk;
  logic SYS_reset;
  int   total;
  int   bad;

  pc_exc_unit_if #(.PC_W(32), .N_EXC(4)) bus ();

  pc_exc_unit #(.PC_W(32), .N_EXC(4), .RESET_PC(32'h0), .VEC_PC(32'h80)) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  initial begin
    SYS_clk = 1'b0;
    forever #5 SYS_clk = ~SYS_clk;
  end

  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_exl, m_taken;
  logic [3:0]  m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0; m_exl = 1'b0; m_taken = 1'b0; m_mask = 4'hF;
  endtask

  // Next state computed from the rule list with plain integer arithmetic.
  task automatic model_step();
    logic [3:0] pend;
    longint     off;
    pend    = bus.exc_req & m_mask;
    m_taken = 1'b0;
    if (bus.load) begin
      m_pc = bus.load_val - (bus.load_val % 4);
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (!m_exl && pend != 0) begin
      for (int b = 3; b >= 0; b--) if (pend[b]) m_cause = 2'(b);
      m_epc = m_pc; m_exl = 1'b1; m_taken = 1'b1; m_pc = 32'h80;
    end else if (bus.eret && m_exl) begin
      m_pc = m_epc; m_exl = 1'b0;
    end else if (bus.jump) begin
      m_pc = 32'(((longint'(m_pc) + 4) / 268435456) * 268435456 + longint'(bus.jump_idx) * 4);
    end else if (bus.branch_taken) begin
      off  = longint'($signed(bus.branch_off)) * 4;
      m_pc = 32'(longint'(m_pc) + 4 + off);
    end else begin
      m_pc = 32'(longint'(m_pc) + 4);
    end
    if (bus.mask_we) m_mask = bus.mask_wdata;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},        bus.pc,        m_pc);
    chk({tag, ".pc_plus4"},  bus.pc_plus4,  32'(longint'(m_pc) + 4));
    chk({tag, ".epc"},       bus.epc,       m_epc);
    chk({tag, ".cause"},     32'(bus.cause), 32'(m_cause));
    chk({tag, ".exl"},       32'(bus.exl),  32'(m_exl));
    chk({tag, ".exc_taken"}, 32'(bus.exc_taken), 32'(m_taken));
    chk({tag, ".mask"},      32'(bus.mask), 32'(m_mask));
  endtask

  task automatic idle();
    bus.stall = 0; bus.load = 0; bus.load_val = 0; bus.branch_taken = 0; bus.branch_off = 0;
    bus.jump = 0; bus.jump_idx = 0; bus.exc_req = 0; bus.eret = 0; bus.mask_we = 0; bus.mask_wdata = 0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge SYS_clk);
    #1;
    chk_all(tag);
    idle();
  endtask

  initial begin
    total = 0; bad = 0;
    idle();
    SYS_reset = 1'b1;
    model_reset();
    #12;
    chk_all("reset");
    SYS_reset = 1'b0;

    tick("seq1"); tick("seq2"); tick("seq3");
    chk("seq_pc12", bus.pc, 32'hC);

    bus.load = 1; bus.load_val = 32'h10; tick("load10");
    bus.branch_taken = 1; bus.branch_off = 16'hFFFE; tick("br_back");
    chk("br_pc0c", bus.pc, 32'hC);
    bus.jump = 1; bus.jump_idx = 26'h40; tick("jump");
    chk("jump_pc100", bus.pc, 32'h100);

    bus.load = 1; bus.load_val = 32'h20; tick("load20");
    bus.exc_req = 4'b1010; tick("exc_acc");
    chk("exc_pc80", bus.pc, 32'h80);
    chk("exc_cause1", 32'(bus.cause), 32'd1);
    bus.exc_req = 4'b0001; tick("exc_ignored_exl");
    chk("exc_pc84", bus.pc, 32'h84);
    bus.eret = 1; tick("eret");
    chk("eret_pc20", bus.pc, 32'h20);

    bus.mask_we = 1; bus.mask_wdata = 4'b1011; tick("mask_wr");
    bus.exc_req = 4'b0100; tick("masked_req");
    bus.exc_req = 4'b0001; bus.mask_we = 1; bus.mask_wdata = 4'b0000; tick("old_mask_used");
    bus.eret = 1; tick("eret2");
    bus.mask_we = 1; bus.mask_wdata = 4'hF; tick("mask_restore");

    bus.stall = 1; bus.exc_req = 4'b0001; tick("stall_exc");
    bus.stall = 1; bus.load = 1; bus.load_val = 32'h203; tick("stall_load");
    chk("load_pc200", bus.pc, 32'h200);
    bus.eret = 1; bus.jump = 1; bus.jump_idx = 26'h3; tick("eret_noop_jump");
    bus.jump = 1; bus.jump_idx = 26'h11; bus.branch_taken = 1; bus.branch_off = 16'h7; tick("jump_over_br");
    bus.load = 1; bus.load_val = 32'hFFFF_FFFC; tick("load_top");
    tick("wrap");
    chk("wrap_pc0", bus.pc, 32'h0);
    bus.load = 1; bus.load_val = 32'hF000_0000; tick("load_hi");
    bus.jump = 1; bus.jump_idx = 26'h5; tick("jump_region");

    for (int n = 0; n < 400; n++) begin
      bus.load         = ($urandom % 16) == 0;
      bus.stall        = ($urandom % 8) == 0;
      bus.load_val     = $urandom;
      bus.branch_taken = ($urandom % 3) == 0;
      bus.branch_off   = 16'($urandom);
      bus.jump         = ($urandom % 6) == 0;
      bus.jump_idx     = 26'($urandom);
      bus.exc_req      = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      bus.eret         = ($urandom % 4) == 0;
      bus.mask_we      = ($urandom % 10) == 0;
      bus.mask_wdata   = 4'($urandom);
      tick("rand");
    end

    bus.mask_we = 1; bus.mask_wdata = 4'hF; tick("mask_full");
    if (bus.exl) begin
      bus.eret = 1; tick("leave_handler");
    end
    bus.exc_req = 4'b0100; tick("exc_before_reset");
    chk("exl_set", 32'(bus.exl), 32'd1);
    #2;
    SYS_reset = 1'b1;
    #1;
    model_reset();
    chk("async_pc", bus.pc, 32'h0);
    chk("async_exl", 32'(bus.exl), 32'd0);
    chk("async_epc", bus.epc, 32'h0);
    chk_all("async_reset");
    #1;
    SYS_reset = 1'b0;
    tick("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_exc_unit.md
PC_EXC_UNIT -- requirements
Module: pc_exc_unit

Interface
REQ-001 SHALL take parameter PC_W, default 32, PC width (minimum 28).
REQ-002 SHALL take parameter N_EXC, default 4, number of exception sources (2..16).
REQ-003 SHALL take parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL take parameter VEC_PC, default 'h80, exception handler entry address.
REQ-005 SHALL define localparam CAUSE_W = clog2(N_EXC).
REQ-006 SHALL have port SYS_clk, in, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port SYS_reset, in, 1, asynchronous active-high reset.
REQ-008 SHALL have port stall, in, 1, hold the PC this cycle.
REQ-009 SHALL have port load, in, 1, force PC to load_val.
REQ-010 SHALL have port load_val, in, PC_W, external PC value.
REQ-011 SHALL have port branch_taken, in, 1, take the branch.
REQ-012 SHALL have port branch_off, in, 16, signed word offset.
REQ-013 SHALL have port jump, in, 1, absolute jump.
REQ-014 SHALL have port jump_idx, in, 26, word index of the jump target.
REQ-015 SHALL have port exc_req, in, N_EXC, level exception requests; bit 0 has the highest priority.
REQ-016 SHALL have port eret, in, 1, return from exception.
REQ-017 SHALL have ports mask_we (in, 1) and mask_wdata (in, N_EXC), the exception-mask write port.
REQ-018 SHALL have ports pc and pc_plus4 (out, PC_W each): the current PC and PC+4.
REQ-019 SHALL have ports epc (out, PC_W) and cause (out, CAUSE_W): the saved PC and the exception index.
REQ-020 SHALL have ports exl (out, 1, handler active), exc_taken (out, 1, one-cycle pulse) and mask (out, N_EXC, current mask).

Function
REQ-021 pc_plus4 SHALL equal pc+4 combinationally; all PC arithmetic SHALL wrap modulo 2^PC_W.
REQ-022 An exception SHALL be accepted on a cycle when:
- load = 0,
- stall = 0,
- exl = 0, and
- (exc_req & mask) != 0.
REQ-023 Next-PC priority SHALL be:
- load: pc <= {load_val[PC_W-1:2], 2'b00}; load applies even when stall = 1.
- stall: pc holds.
- accepted exception: pc <= VEC_PC.
- eret with exl = 1: pc <= epc.
- jump: pc <= {pc_plus4[PC_W-1:28], jump_idx, 2'b00}.
- branch_taken: pc <= pc_plus4 + (sign_extend(branch_off) << 2).
- otherwise: pc <= pc_plus4.
REQ-024 On exception acceptance, in the same edge:
- epc <= pc;
- cause <= index of the lowest set bit of (exc_req & mask);
- exl <= 1.
REQ-025 exc_taken SHALL be registered and high for exactly the one cycle in which pc first equals VEC_PC after acceptance.
REQ-026 While exl = 1, exc_req SHALL be ignored and not latched (no nesting, no pending queue).
REQ-027 eret with exl = 1 SHALL clear exl; eret with exl = 0 SHALL be a no-op and fall through to the lower priorities.
REQ-028 Exception acceptance and eret in the same cycle are impossible (exl differs); jump plus branch_taken in the same cycle SHALL resolve to jump.
REQ-029 mask_we SHALL update mask on the edge; a request masked by the same-cycle write SHALL use the old mask.
REQ-030 load SHALL NOT alter epc, cause, exl or mask.

Reset
REQ-031 Reset SHALL set, asynchronously:
- pc = RESET_PC,
- epc = 0,
- cause = 0,
- exl = 0,
- exc_taken = 0,
- mask = all ones.
REQ-032 Reset asserted mid-handler SHALL abandon the handler; no eret is needed afterwards.

Structure
REQ-033 Package pc_exc_pkg SHALL hold the PC_W, N_EXC, RESET_PC and VEC_PC defaults and the next-PC select enum (SEL_LOAD, SEL_HOLD, SEL_EXC, SEL_ERET, SEL_JUMP, SEL_BR, SEL_SEQ).
REQ-034 A sub-module prio_enc SHALL convert N_EXC request bits into an index plus a valid bit.

Verification
REQ-035 Scenario: release reset, no control inputs for 3 cycles -> pc = 0, 4, 8, 12; exl = 0; mask = 4'hF.
REQ-036 Scenario: at pc = 'h10, branch_off = -2 (16'hFFFE) with branch_taken -> next pc = 'h0C; jump_idx = 26'h40 -> pc = 'h100.
REQ-037 Scenario: at pc = 'h20, exc_req = 4'b1010 -> next pc = 'h80, epc = 'h20, cause = 1, exl = 1, exc_taken pulses one cycle; then eret -> pc = 'h20, exl = 0.
REQ-038 Scenario: exc_req = 4'b0001 with exl = 1 -> ignored, pc advances +4; exc_req = 4'b0100 with mask = 4'b1011 -> ignored.
REQ-039 Scenario: stall = 1 with exc_req = 1 -> pc holds and no acceptance; load = 1, load_val = 'h203, stall = 1 -> pc = 'h200.
REQ-040 Scenario: SYS_reset asserted between clock edges while exl = 1 -> immediately pc = 0, exl = 0, epc = 0.
